fpu_result_collector: RTL and testbench
=======================================

# fpu_result_collector

Downstream stage of the single-precision FPU. It tracks every operation issued to the FPU through a fixed-latency shadow pipeline and captures the FPU result and exception flags on the cycle they become valid. It queues each captured result in a small FIFO with a ready/valid output and keeps sticky exception status for software. It also flags FPU protocol violations: overflow and underflow asserted together on one result.

## Interface
Parameters:
- LATENCY, 4, FPU cycles from operand issue to valid `out`/flags; legal range 1–16.
- DEPTH, 4, result FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk externally.
- issue_i  in  1  an operation enters the FPU this cycle.
- fpu_op_i  in  3  fpu_op presented with the issue.
- fpu_out_i  in  32  FPU `out` bus.
- overflow_i, underflow_i, div_by_zero_i, ine_i, qnan_i, snan_i  in  1 each  FPU exception outputs.
- res_valid_o  out  1  FIFO head valid.
- res_ready_i  in  1  consumer accepts the head.
- res_data_o  out  32  head result.
- res_op_o  out  3  head opcode tag.
- res_flags_o  out  6  head flags {snan,qnan,ine,div_by_zero,underflow,overflow}, bit 5..0.
- sticky_o  out  6  OR of flags of all captured results since reset or clear; same bit order.
- sticky_clr_i  in  1  clears sticky_o, dropped_o and proto_err_o.
- dropped_o  out  1  sticky; a result was lost because the FIFO was full.
- proto_err_o  out  1  sticky; a captured result had overflow_i and underflow_i both 1.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy_o  out  1  any op in flight or FIFO non-empty.

## Operation
- Shadow pipeline: LATENCY stages of {valid, op[2:0]}. Stage 0 loads {issue_i, fpu_op_i} every cycle. Each stage shifts every cycle and never stalls, because the FPU does not stall.
- Capture: when the last stage is valid, fpu_out_i and the flags are sampled that cycle.
- Flag masking: div_by_zero is kept only when op tag == 3 (divide). For any other op it is forced to 0 in the stored flags and in the sticky update.
- Push: a captured result is written to the FIFO when count < DEPTH, or when count == DEPTH and a pop occurs the same cycle.
- Drop: a capture with the FIFO full and no pop is discarded and sets dropped_o. Its flags still update sticky_o and proto_err_o.
- Pop: on res_valid_o && res_ready_i. A simultaneous push and pop leaves count unchanged.
- proto_err_o is set on any capture where overflow_i && underflow_i.
- Sticky update: next = (sticky_clr_i ? 0 : current) | captured flags. A capture in the same cycle as a clear therefore survives the clear. dropped_o and proto_err_o follow the same rule.
- busy_o = OR of all pipeline valid bits, or count != 0.
- FIFO pointers wrap modulo DEPTH. Head outputs come directly from storage (no output register bubble).

## Timing
- Reset (rst_n = 0, asynchronous): pipeline valids 0, FIFO pointers 0, count_o 0, res_valid_o 0, res_data_o 0, res_op_o 0, res_flags_o 0, sticky_o 0, dropped_o 0, proto_err_o 0, busy_o 0. In-flight ops are discarded. Reset mid-operation loses them with no flag.
- An issue at edge t is captured at edge t+LATENCY. res_valid_o rises after edge t+LATENCY, so issue-to-output is LATENCY+1 cycles of visibility.
- Back-to-back issues every cycle are supported. Throughput is 1 result per cycle while res_ready_i is held high.
- res_valid_o and the head fields stay stable until popped.
- Empty FIFO with a capture: the result appears on the next cycle. There is no same-cycle bypass.

## Test plan
- Single add: issue fpu_op=0 with LATENCY=4, fpu_out_i=0x3F800000 at cycle t+4 -> res_valid_o=1 at t+5, res_data_o=0x3F800000, res_op_o=0, res_flags_o=0.
- Divide by zero: fpu_op=3 with div_by_zero_i=1 at capture -> res_flags_o=6'b000100, sticky_o[2]=1. Same with fpu_op=2 -> res_flags_o=0 and sticky_o[2] unchanged.
- Overflow: 6 back-to-back issues with res_ready_i=0 and DEPTH=4 -> count_o=4, dropped_o=1, first 4 results retained in order. Then raise res_ready_i -> 4 pops, count_o=0, busy_o=0.
- Full FIFO, push and pop in the same cycle -> no drop, count_o stays 4, the new result is at the tail.
- Clear collision: a capture with overflow_i=1 and underflow_i=1 in the same cycle as sticky_clr_i=1, while sticky_o=6'b001000 -> sticky_o=6'b000011, proto_err_o=1.
- Async reset asserted with 3 ops in flight and 2 queued -> all outputs 0 immediately. No result appears after rst_n rises.

Source files
------------

// File: rtl/fpu_result_collector.sv
// Collects FPU results behind a fixed-latency shadow pipeline into a small FIFO,
// keeping sticky exception status plus drop and protocol-violation indicators.
module fpu_result_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_i,
  input  logic [2:0]               fpu_op_i,
  input  logic [31:0]              fpu_out_i,
  input  logic                     overflow_i,
  input  logic                     underflow_i,
  input  logic                     div_by_zero_i,
  input  logic                     ine_i,
  input  logic                     qnan_i,
  input  logic                     snan_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [31:0]              res_data_o,
  output logic [2:0]               res_op_o,
  output logic [5:0]               res_flags_o,
  output logic [5:0]               sticky_o,
  input  logic                     sticky_clr_i,
  output logic                     dropped_o,
  output logic                     proto_err_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
  localparam logic [2:0]  OP_DIV     = 3'd3;

  logic [LATENCY-1:0] r_pipe_valid;
  logic [2:0]         r_pipe_op [LATENCY];

  logic [31:0]        r_mem_data  [DEPTH];
  logic [2:0]         r_mem_op    [DEPTH];
  logic [5:0]         r_mem_flags [DEPTH];

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic [5:0]         r_sticky;
  logic               r_dropped;
  logic               r_proto_err;

  logic               w_cap_valid;
  logic [2:0]         w_cap_op;
  logic [5:0]         w_cap_flags;
  logic [5:0]         w_cap_sticky;
  logic               w_nonempty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_proto_hit;

  // Shadow pipeline: mirrors the FPU latency, never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_valid <= '0;
    end else begin
      r_pipe_valid[0] <= issue_i;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_pipe_op[0] <= fpu_op_i;
    for (int i = 1; i < LATENCY; i++) begin
      r_pipe_op[i] <= r_pipe_op[i-1];
    end
  end

  assign w_cap_valid = r_pipe_valid[LATENCY-1];
  assign w_cap_op    = r_pipe_op[LATENCY-1];

  // Divide-by-zero is only meaningful for the divide opcode.
  assign w_cap_flags = {snan_i, qnan_i, ine_i,
                        div_by_zero_i & (w_cap_op == OP_DIV),
                        underflow_i, overflow_i};

  assign w_cap_sticky = w_cap_valid ? w_cap_flags : 6'd0;
  assign w_proto_hit  = w_cap_valid & overflow_i & underflow_i;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == FULL_COUNT);
  assign w_pop      = w_nonempty & res_ready_i;
  assign w_push     = w_cap_valid & (~w_full | w_pop);
  assign w_drop     = w_cap_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr]  <= fpu_out_i;
      r_mem_op[r_wr_ptr]    <= w_cap_op;
      r_mem_flags[r_wr_ptr] <= w_cap_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A capture in the same cycle as a clear survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky    <= '0;
      r_dropped   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_sticky    <= (sticky_clr_i ? 6'd0 : r_sticky) | w_cap_sticky;
      r_dropped   <= (sticky_clr_i ? 1'b0 : r_dropped) | w_drop;
      r_proto_err <= (sticky_clr_i ? 1'b0 : r_proto_err) | w_proto_hit;
    end
  end

  // Head fields are zero while empty so stale storage never leaks out.
  assign res_valid_o = w_nonempty;
  assign res_data_o  = w_nonempty ? r_mem_data[r_rd_ptr]  : 32'd0;
  assign res_op_o    = w_nonempty ? r_mem_op[r_rd_ptr]    : 3'd0;
  assign res_flags_o = w_nonempty ? r_mem_flags[r_rd_ptr] : 6'd0;

  assign sticky_o    = r_sticky;
  assign dropped_o   = r_dropped;
  assign proto_err_o = r_proto_err;
  assign count_o     = r_count;
  assign busy_o      = (|r_pipe_valid) | w_nonempty;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Randomized scoreboard bench for fpu_result_collector: a queue-based model
// predicts each accepted result and a negedge monitor compares DUT outputs.
module tb_fpu_result_collector;
  localparam int L  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_i;
  logic [2:0]    fpu_op_i;
  logic [31:0]   fpu_out_i;
  logic          overflow_i, underflow_i, div_by_zero_i, ine_i, qnan_i, snan_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [31:0]   res_data_o;
  logic [2:0]    res_op_o;
  logic [5:0]    res_flags_o;
  logic [5:0]    sticky_o;
  logic          sticky_clr_i;
  logic          dropped_o;
  logic          proto_err_o;
  logic [CW-1:0] count_o;
  logic          busy_o;

  fpu_result_collector #(.LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .issue_i(issue_i), .fpu_op_i(fpu_op_i),
    .fpu_out_i(fpu_out_i), .overflow_i(overflow_i), .underflow_i(underflow_i),
    .div_by_zero_i(div_by_zero_i), .ine_i(ine_i), .qnan_i(qnan_i), .snan_i(snan_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_op_o(res_op_o), .res_flags_o(res_flags_o), .sticky_o(sticky_o),
    .sticky_clr_i(sticky_clr_i), .dropped_o(dropped_o), .proto_err_o(proto_err_o),
    .count_o(count_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [2:0]  op;
    bit [31:0] d;
    bit [5:0]  f;
  } sched_t;

  typedef struct {
    bit [31:0] d;
    bit [2:0]  op;
    bit [5:0]  f;
  } res_t;

  // sched[edge % 32] holds what the FPU presents at that capture edge.
  sched_t   sched [32];
  res_t     sb_q [$];
  int       m_count;
  bit [5:0] m_sticky;
  bit       m_dropped, m_proto, m_busy;
  int       next_edge;
  int       n_vec = 0;
  int       n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) sched[i].v = 1'b0;
    sb_q.delete();
    m_count   = 0;
    m_sticky  = '0;
    m_dropped = 1'b0;
    m_proto   = 1'b0;
    m_busy    = 1'b0;
  endtask

  // Applies the rules for the edge that just occurred, using the inputs still held.
  task automatic model_step();
    int       slot;
    sched_t   s;
    bit       pop, drop;
    bit [5:0] f;
    res_t     r;
    slot = next_edge % 32;
    if (!rst_n) begin
      model_reset();
    end else begin
      s    = sched[slot];
      pop  = (m_count > 0) && res_ready_i;
      drop = 1'b0;
      f    = '0;
      if (s.v) begin
        f = s.f;
        if (s.op != 3'd3) f[2] = 1'b0;
        if (m_count < D || pop) begin
          r.d = s.d; r.op = s.op; r.f = f;
          sb_q.push_back(r);
          m_count++;
        end else begin
          drop = 1'b1;
        end
      end
      if (pop) m_count--;
      m_sticky  = (sticky_clr_i ? 6'd0 : m_sticky) | f;
      m_dropped = (sticky_clr_i ? 1'b0 : m_dropped) | drop;
      m_proto   = (sticky_clr_i ? 1'b0 : m_proto) | (s.v && f[0] && f[1]);
      sched[slot].v = 1'b0;
      m_busy = (m_count != 0);
      for (int i = 0; i < 32; i++) if (sched[i].v) m_busy = 1'b1;
    end
    next_edge++;
  endtask

  task automatic drive(input bit iss, input bit [2:0] op, input bit [31:0] d,
                       input bit [5:0] f, input bit rdy, input bit clr);
    sched_t   s;
    bit [5:0] pf;
    s = sched[next_edge % 32];
    issue_i      = iss;
    fpu_op_i     = op;
    res_ready_i  = rdy;
    sticky_clr_i = clr;
    if (s.v) begin
      fpu_out_i = s.d;
      pf        = s.f;
    end else begin
      fpu_out_i = $urandom;
      pf        = 6'($urandom);
    end
    {snan_i, qnan_i, ine_i, div_by_zero_i, underflow_i, overflow_i} = pf;
    if (iss) begin
      sched[(next_edge + L) % 32].v  = 1'b1;
      sched[(next_edge + L) % 32].op = op;
      sched[(next_edge + L) % 32].d  = d;
      sched[(next_edge + L) % 32].f  = f;
    end
  endtask

  task automatic cycle(input bit iss, input bit [2:0] op, input bit [31:0] d,
                       input bit [5:0] f, input bit rdy, input bit clr);
    @(posedge clk);
    #1 model_step();
    #1 drive(iss, op, d, f, rdy, clr);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 32'd0, 6'd0, rdy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  res_valid_o, 0);
    check({tag, "_data"},   res_data_o,  0);
    check({tag, "_op"},     res_op_o,    0);
    check({tag, "_flags"},  res_flags_o, 0);
    check({tag, "_sticky"}, sticky_o,    0);
    check({tag, "_drop"},   dropped_o,   0);
    check({tag, "_proto"},  proto_err_o, 0);
    check({tag, "_count"},  count_o,     0);
    check({tag, "_busy"},   busy_o,      0);
  endtask

  // Monitor: compares status every cycle and the head against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      check("count",  count_o,     m_count);
      check("valid",  res_valid_o, (m_count != 0));
      check("sticky", sticky_o,    m_sticky);
      check("drop",   dropped_o,   m_dropped);
      check("proto",  proto_err_o, m_proto);
      check("busy",   busy_o,      m_busy);
      if (res_valid_o) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL head_unexpected: got data 0x%08h expected no result", res_data_o);
        end else begin
          check("head_data",  res_data_o,  sb_q[0].d);
          check("head_op",    res_op_o,    sb_q[0].op);
          check("head_flags", res_flags_o, sb_q[0].f);
          if (res_ready_i) begin
            $display("pop data=0x%08h op=%0d flags=%06b", res_data_o, res_op_o, res_flags_o);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    next_edge = 0;
    model_reset();
    drive(1'b0, 3'd0, 32'd0, 6'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    #1 check_all_zero("reset");
    idle(1, 1'b0);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Single add: result visible one cycle after the capture edge.
    cycle(1'b1, 3'd0, 32'h3F80_0000, 6'd0, 1'b0, 1'b0);
    idle(L + 1, 1'b0);
    @(negedge clk);
    check("add_valid", res_valid_o, 1);
    check("add_data",  res_data_o,  32'h3F80_0000);
    check("add_flags", res_flags_o, 0);
    idle(L + D + 2, 1'b1);

    // Divide by zero kept for divide, masked otherwise.
    cycle(1'b1, 3'd3, $urandom, 6'b000100, 1'b1, 1'b0);
    idle(L + 2, 1'b1);
    check("div_sticky", sticky_o, 6'b000100);
    cycle(1'b1, 3'd2, $urandom, 6'b000100, 1'b1, 1'b1);
    idle(L + 2, 1'b1);
    check("nodiv_sticky", sticky_o, 6'b000000);

    // Overflow: six issues into a stalled FIFO.
    for (int i = 0; i < 6; i++) cycle(1'b1, 3'(i), $urandom, 6'd0, 1'b0, 1'b0);
    idle(L + 1, 1'b0);
    @(negedge clk);
    check("ovf_count", count_o, 4);
    check("ovf_drop",  dropped_o, 1);
    idle(D + 2, 1'b1);
    @(negedge clk);
    check("ovf_drain_count", count_o, 0);
    check("ovf_drain_busy",  busy_o, 0);

    // Full FIFO with push and pop on the same edge.
    cycle(1'b0, 3'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'(i + 1), $urandom, 6'd0, 1'b0, 1'b0);
    idle(L - 1, 1'b0);
    cycle(1'b0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 32'd0, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("pp_count", count_o, 4);
    check("pp_drop",  dropped_o, 0);
    idle(D + 2, 1'b1);

    // Clear colliding with a capture carrying overflow and underflow.
    cycle(1'b0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b1);
    cycle(1'b1, 3'd1, $urandom, 6'b001000, 1'b1, 1'b0);
    idle(L + 2, 1'b1);
    cycle(1'b1, 3'd1, $urandom, 6'b000011, 1'b1, 1'b0);
    idle(L - 1, 1'b1);
    cycle(1'b0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b1);
    cycle(1'b0, 3'd0, 32'd0, 6'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("clr_sticky", sticky_o, 6'b000011);
    check("clr_proto",  proto_err_o, 1);
    idle(L + 2, 1'b1);

    // Asynchronous reset with three in flight and two queued.
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'(i), $urandom, 6'b111111, 1'b0, 1'b0);
    idle(L - 2, 1'b0);
    #1 check("pre_rst_count", count_o, 2);
    rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    idle(3, 1'b1);
    rst_n = 1'b1;
    idle(L + 3, 1'b1);
    @(negedge clk);
    check("post_rst_valid", res_valid_o, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), $urandom,
            6'($urandom & $urandom), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 19) == 0));
    end
    idle(L + D + 4, 1'b1);
    @(negedge clk);
    check("final_busy", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
